// File: rtl/fir_fold_pkg.sv
// Shared types and default sizing for the folded FIR MAC sequencer.
package fir_fold_pkg;

   localparam int unsigned DefTaps  = 16;
   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefCoefW = 11;
   localparam int unsigned DefProdW = DefDataW + DefCoefW;
   localparam int unsigned DefAddrW = $clog2(DefTaps);
   localparam int unsigned DefAccW  = DefProdW + DefAddrW;
   localparam int unsigned DefShift = 10;
   localparam int unsigned DefOutW  = 16;

   typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_e;

endpackage

// File: rtl/fir_fold_out_scale.sv
// Accumulator to output-sample scaling: arithmetic shift, then clamp (FIR_OUT_SAT_EN) or wrap.
module fir_fold_out_scale #(
   parameter int unsigned ACC_W = 31,
   parameter int unsigned SHIFT = 10,
   parameter int unsigned OUT_W = 16
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic        [OUT_W-1:0] data_o
);

`ifdef FIR_OUT_SAT_EN
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] sat_max;
   logic signed [ACC_W-1:0] sat_min;

   assign sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   assign sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      shifted = acc_i >>> SHIFT;
      if (shifted > sat_max) begin
         data_o = sat_max[OUT_W-1:0];
      end else if (shifted < sat_min) begin
         data_o = sat_min[OUT_W-1:0];
      end else begin
         data_o = shifted[OUT_W-1:0];
      end
   end
`else
   assign data_o = OUT_W'(acc_i >>> SHIFT);
`endif

endmodule

// File: rtl/fir_fold_mac_sched.sv
// Folded FIR sequencer: one shared multiplier, TAPS MAC steps per sample, registered output.
// Optional output saturation via FIR_OUT_SAT_EN (see fir_fold_out_scale).
module fir_fold_mac_sched
   import fir_fold_pkg::*;
#(
   parameter int unsigned TAPS   = DefTaps,
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned COEF_W = DefCoefW,
   parameter int unsigned PROD_W = DATA_W + COEF_W,
   parameter int unsigned ACC_W  = PROD_W + $clog2(TAPS),
   parameter int unsigned SHIFT  = DefShift,
   parameter int unsigned OUT_W  = DefOutW
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data,
   output logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic        [COEF_W-1:0]  coef_q,
   output logic signed [DATA_W-1:0]  mul_a,
   output logic        [COEF_W-1:0]  mul_b,
   input  logic signed [PROD_W-1:0]  mul_p,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic        [OUT_W-1:0]   out_data,
   output logic                      busy
);

   localparam int unsigned AddrW = $clog2(TAPS);

   state_e                   state_q, state_d;
   logic [AddrW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0]         coef_addr_q, coef_addr_d;
   logic [AddrW-1:0]         rd_idx;
   logic signed [DATA_W-1:0] line_q [TAPS];
   logic signed [DATA_W-1:0] line_d [TAPS];
   logic signed [DATA_W-1:0] sample_q, sample_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  prod_ext;
   logic                     out_valid_q, out_valid_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic [OUT_W-1:0]         scaled;
   logic                     mac_active;
   logic                     acc_en;

   fir_fold_out_scale #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_out_scale (
      .acc_i  (acc_q),
      .data_o (scaled)
   );

   assign prod_ext   = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
   assign rd_idx     = wr_ptr_q - coef_addr_q;
   assign mac_active = (state_q == StMac) || (state_q == StDrain);
   // Product of step k lands one cycle after issue, so step 0 of MAC carries nothing yet.
   assign acc_en     = ((state_q == StMac) && (coef_addr_q != '0)) || (state_q == StDrain);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      coef_addr_d = coef_addr_q;
      line_d      = line_q;
      sample_d    = sample_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (acc_en) begin
         acc_d = acc_q + prod_ext;
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               line_d[wr_ptr_q] = in_data;
               acc_d            = '0;
               coef_addr_d      = '0;
               state_d          = StMac;
            end
         end
         StMac: begin
            sample_d    = line_q[rd_idx];
            coef_addr_d = coef_addr_q + 1'b1;
            if (coef_addr_q == AddrW'(TAPS - 1)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            state_d = StOut;
         end
         StOut: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = scaled;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               wr_ptr_d    = wr_ptr_q + 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         coef_addr_q <= '0;
         sample_q    <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < TAPS; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         coef_addr_q <= coef_addr_d;
         sample_q    <= sample_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         line_q      <= line_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign coef_addr = coef_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   // Quiet the external multiplier whenever no product is being consumed.
   assign mul_a     = mac_active ? sample_q : '0;
   assign mul_b     = mac_active ? coef_q : '0;

endmodule
